wishbone_arbiter: RTL and testbench
===================================

# wishbone_arbiter

Round-robin arbiter sharing one Wishbone B4 pipelined slave port (e.g. a WishboneSlaveXactor instance) between N_MASTERS Wishbone masters. It grants the bus per bus cycle (CYC), muxes the owner's request onto the slave and routes STALL/ACK/DAT back only to the owner. It tracks outstanding requests and throttles the owner at MAX_OUTSTANDING. It sits between the interconnect's master ports and a single slave transactor.

## Interface
- N_MASTERS, 2, number of masters (2..8)
- ADR_W, 32, address width
- DAT_W, 32, data width; SEL width is DAT_W/8
- MAX_OUTSTANDING, 8, maximum accepted-but-unacknowledged requests per bus cycle (≥1)

- CLK  in  1  clock
- RST_N  in  1  reset, asynchronous, active-low
- M_CYC_I  in  N_MASTERS  per-master CYC
- M_STB_I  in  N_MASTERS  per-master STB
- M_WE_I  in  N_MASTERS  per-master WE
- M_ADR_I  in  N_MASTERS×ADR_W  per-master address
- M_SEL_I  in  N_MASTERS×DAT_W/8  per-master byte select
- M_DAT_I  in  N_MASTERS×DAT_W  per-master write data
- M_STALL_O  out  N_MASTERS  per-master stall
- M_ACK_O  out  N_MASTERS  per-master ack
- M_DAT_O  out  DAT_W  read data, broadcast; valid only with the master's ACK
- S_CYC_O, S_STB_O, S_WE_O  out  1  slave request
- S_ADR_O  out  ADR_W, S_SEL_O  out  DAT_W/8, S_DAT_O  out  DAT_W  slave request fields
- S_STALL_I, S_ACK_I  in  1  slave responses
- S_DAT_I  in  DAT_W  slave read data
- GRANT_O  out  N_MASTERS  one-hot current owner, all-zero when idle

## Operation
- State: grant_valid, grant_idx, last_idx, outstanding (0..MAX_OUTSTANDING).
- IDLE (grant_valid=0): at a clock edge where any M_CYC_I is high, grant the first requester searching from last_idx+1 upward with wrap. Set grant_valid=1 and last_idx=grant_idx.
- OWNED: S_CYC_O=M_CYC_I[g]. S_STB_O=M_STB_I[g] & ~throttle, with throttle = (outstanding==MAX_OUTSTANDING). S_WE/ADR/SEL/DAT come from master g.
- The owner sees M_STALL_O[g] = S_STALL_I | throttle and M_ACK_O[g] = S_ACK_I & M_CYC_I[g]. Every other master sees STALL=1 and ACK=0.
- Accept = S_STB_O & ~S_STALL_I. The counter is outstanding += accept − S_ACK_I, saturating at 0. A simultaneous accept and ack leaves it unchanged.
- Release: at an edge where M_CYC_I[g]=0, clear outstanding to 0. At the same edge, re-arbitrate among the current M_CYC_I, searching from g+1. If no requester is present, go to IDLE.
- Abort: when the owner drops CYC with outstanding>0, the slave sees CYC fall and any late S_ACK_I is discarded (not routed).
- Owner keeps the grant for the whole CYC; there is no preemption.

## Timing
- Reset values: grant_valid=0, last_idx=N_MASTERS−1 (master 0 wins first), outstanding=0.
- Reset values of outputs: S_CYC_O=S_STB_O=0, M_ACK_O=0, M_STALL_O=all-ones, GRANT_O=0.
- Arbitration latency: request CYC rising at edge k is granted from cycle k+1. The first STB can reach the slave in that cycle.
- Handover: the owner drops CYC in cycle k. A pending master is granted in cycle k+1, so there is zero idle cycles between owners.
- The request/stall path and the ACK path are combinational. There is no added latency on either.
- Throttle: with outstanding==MAX_OUTSTANDING, STB to the slave is gated that cycle. If an ACK arrives in the same cycle, throttle still applies; STB is released the next cycle.
- Reset asserted mid-cycle forces all outputs to their reset values asynchronously.

## Structure
- Shared package wishbone_pkg holds:
  - ADR_W/DAT_W defaults;
  - the wb_req_t struct (we, adr, sel, dat);
  - the function clog2-based index type.
- Sub-module rr_pick: combinational round-robin picker (req vector, last_idx → valid, idx). It is reusable by other schedulers in the codebase.

## Test plan
- Single master: M0 issues 3 reads with a 1-cycle slave ACK delay → GRANT_O=01 from cycle 1, 3 ACKs to M0 only, M1 ACK=0 throughout.
- Contention: M0 and M1 raise CYC in the same cycle after reset → M0 granted. M0 drops CYC in cycle 5 → GRANT_O=10 in cycle 6. Next tie → M0 wins again (rotation).
- Throttle: MAX_OUTSTANDING=2, slave never ACKs, M0 streams STB → 2 accepts. Then M0 sees STALL=1 and S_STB_O=0. One ACK → the next STB is accepted.
- Slave stall: S_STALL_I=1 for 4 cycles → M0 STALL=1, outstanding unchanged. The request held stable is accepted on release.
- Abort: M1 drops CYC with outstanding=2 → counter is 0 next cycle. A late S_ACK_I is not routed to M0 or M1.
- Reset mid-transfer: RST_N low while M0 is owned with outstanding=3 → S_CYC_O=0, GRANT_O=0 and all stalls=1 immediately. After release, M0 wins the first arbitration.

Source files
------------

// File: rtl/wishbone_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : wishbone_pkg                                                     |
// | Purpose : Shared Wishbone B4 types and helpers. Holds the default address  |
// |           and data widths, the request-field bundle muxed by arbiters,     |
// |           the arbiter state encoding and an index-width helper.            |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package wishbone_pkg;

  localparam int WB_ADR_W = 32;
  localparam int WB_DAT_W = 32;
  localparam int WB_SEL_W = WB_DAT_W / 8;

  // Request fields that travel with STB. Sized to the package widths; blocks
  // using narrower buses fill the low bits only.
  typedef struct packed {
    logic                we;
    logic [WB_ADR_W-1:0] adr;
    logic [WB_SEL_W-1:0] sel;
    logic [WB_DAT_W-1:0] dat;
  } wb_req_t;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_OWNED = 1'b1
  } arb_state_t;

  // Width of an index into n items; never less than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : rr_pick                                                          |
// | Purpose : Combinational round-robin picker. Returns the first asserted     |
// |           request searching upward from i_last_idx+1 with wrap-around.     |
// | Ports   : i_req      N-bit request vector                                  |
// |           i_last_idx index of the most recent winner                       |
// |           o_valid    at least one request present                          |
// |           o_idx      index of the winner (0 when o_valid is low)           |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module rr_pick
  import wishbone_pkg::*;
#(
  parameter int N     = 2,
  parameter int IDX_W = idx_width(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_last_idx,
  output logic             o_valid,
  output logic [IDX_W-1:0] o_idx
);

  // Walk the offsets from farthest to nearest so the nearest requester after
  // i_last_idx is the one left standing.
  always_comb begin
    int               w_cand;
    logic [IDX_W-1:0] w_cand_idx;
    o_valid    = 1'b0;
    o_idx      = '0;
    w_cand     = 0;
    w_cand_idx = '0;
    for (int off = N; off >= 1; off--) begin
      w_cand = int'(i_last_idx) + off;
      if (w_cand >= N) begin
        w_cand = w_cand - N;
      end
      w_cand_idx = IDX_W'(w_cand);
      if (i_req[w_cand_idx]) begin
        o_valid = 1'b1;
        o_idx   = w_cand_idx;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/wishbone_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : wishbone_arbiter                                                 |
// | Purpose : Round-robin arbiter sharing one pipelined Wishbone B4 slave      |
// |           between N_MASTERS masters. Grants per bus cycle (CYC), muxes the |
// |           owner onto the slave, routes STALL/ACK back to the owner only    |
// |           and throttles the owner at MAX_OUTSTANDING unacknowledged reqs.  |
// | Ports   : CLK, RST_N (async, active-low)                                   |
// |           M_*_I / M_STALL_O / M_ACK_O : per-master Wishbone ports          |
// |           M_DAT_O                     : read data, broadcast               |
// |           S_*_O / S_*_I               : single slave port                  |
// |           GRANT_O                     : one-hot owner, zero when idle      |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module wishbone_arbiter
  import wishbone_pkg::*;
#(
  parameter int N_MASTERS       = 2,
  parameter int ADR_W           = WB_ADR_W,
  parameter int DAT_W           = WB_DAT_W,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                           CLK,
  input  logic                           RST_N,
  input  logic [N_MASTERS-1:0]           M_CYC_I,
  input  logic [N_MASTERS-1:0]           M_STB_I,
  input  logic [N_MASTERS-1:0]           M_WE_I,
  input  logic [N_MASTERS*ADR_W-1:0]     M_ADR_I,
  input  logic [N_MASTERS*DAT_W/8-1:0]   M_SEL_I,
  input  logic [N_MASTERS*DAT_W-1:0]     M_DAT_I,
  output logic [N_MASTERS-1:0]           M_STALL_O,
  output logic [N_MASTERS-1:0]           M_ACK_O,
  output logic [DAT_W-1:0]               M_DAT_O,
  output logic                           S_CYC_O,
  output logic                           S_STB_O,
  output logic                           S_WE_O,
  output logic [ADR_W-1:0]               S_ADR_O,
  output logic [DAT_W/8-1:0]             S_SEL_O,
  output logic [DAT_W-1:0]               S_DAT_O,
  input  logic                           S_STALL_I,
  input  logic                           S_ACK_I,
  input  logic [DAT_W-1:0]               S_DAT_I,
  output logic [N_MASTERS-1:0]           GRANT_O
);

  localparam int C_SEL_W = DAT_W / 8;
  localparam int C_IDX_W = idx_width(N_MASTERS);
  localparam int C_CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [C_CNT_W-1:0] C_MAX_OUT = C_CNT_W'(MAX_OUTSTANDING);

  arb_state_t             r_state;
  // While owned this is the owner's index; while idle it is the previous
  // owner, which is where the next search starts.
  logic [C_IDX_W-1:0]     r_last_idx;
  logic [N_MASTERS-1:0]   r_grant;
  logic [C_CNT_W-1:0]     r_outstanding;

  logic                   w_pick_valid;
  logic [C_IDX_W-1:0]     w_pick_idx;
  logic [N_MASTERS-1:0]   w_pick_onehot;
  logic                   w_own_cyc;
  logic                   w_own_stb;
  logic                   w_throttle;
  logic                   w_accept;
  logic [C_CNT_W-1:0]     w_out_next;
  wb_req_t                w_req;

  // On release the owner's own CYC is already low, so searching the raw CYC
  // vector from the owner's index excludes it until everyone else is checked.
  rr_pick #(
    .N     (N_MASTERS),
    .IDX_W (C_IDX_W)
  ) u_rr_pick (
    .i_req      (M_CYC_I),
    .i_last_idx (r_last_idx),
    .o_valid    (w_pick_valid),
    .o_idx      (w_pick_idx)
  );

  always_comb begin
    w_pick_onehot = '0;
    for (int m = 0; m < N_MASTERS; m++) begin
      w_pick_onehot[m] = w_pick_valid && (w_pick_idx == C_IDX_W'(m));
    end
  end

  // Owner request mux; r_grant is all-zero when idle so nothing reaches the slave.
  always_comb begin
    w_req     = '0;
    w_own_cyc = 1'b0;
    w_own_stb = 1'b0;
    for (int m = 0; m < N_MASTERS; m++) begin
      if (r_grant[m]) begin
        w_own_cyc                = M_CYC_I[m];
        w_own_stb                = M_STB_I[m];
        w_req.we                 = M_WE_I[m];
        w_req.adr[ADR_W-1:0]     = M_ADR_I[m*ADR_W +: ADR_W];
        w_req.sel[C_SEL_W-1:0]   = M_SEL_I[m*C_SEL_W +: C_SEL_W];
        w_req.dat[DAT_W-1:0]     = M_DAT_I[m*DAT_W +: DAT_W];
      end
    end
  end

  assign w_throttle = (r_outstanding == C_MAX_OUT);
  assign S_CYC_O    = w_own_cyc;
  assign S_STB_O    = w_own_stb & ~w_throttle;
  assign S_WE_O     = w_req.we;
  assign S_ADR_O    = w_req.adr[ADR_W-1:0];
  assign S_SEL_O    = w_req.sel[C_SEL_W-1:0];
  assign S_DAT_O    = w_req.dat[DAT_W-1:0];
  assign w_accept   = S_STB_O & ~S_STALL_I;
  assign M_DAT_O    = S_DAT_I;
  assign GRANT_O    = r_grant;

  // ACK is qualified by the owner's CYC so an acknowledge arriving after an
  // abort is dropped rather than delivered.
  always_comb begin
    M_STALL_O = '1;
    M_ACK_O   = '0;
    for (int m = 0; m < N_MASTERS; m++) begin
      if (r_grant[m]) begin
        M_STALL_O[m] = S_STALL_I | w_throttle;
        M_ACK_O[m]   = S_ACK_I & M_CYC_I[m];
      end
    end
  end

  // Simultaneous accept and ack cancel; a stray ack at zero is ignored.
  always_comb begin
    w_out_next = r_outstanding;
    if (w_accept && !S_ACK_I) begin
      w_out_next = r_outstanding + C_CNT_W'(1);
    end else if (!w_accept && S_ACK_I && (r_outstanding != '0)) begin
      w_out_next = r_outstanding - C_CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state       <= ARB_IDLE;
      r_last_idx    <= C_IDX_W'(N_MASTERS - 1);
      r_grant       <= '0;
      r_outstanding <= '0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_pick_valid) begin
            r_state    <= ARB_OWNED;
            r_last_idx <= w_pick_idx;
            r_grant    <= w_pick_onehot;
          end
        end
        ARB_OWNED: begin
          if (!w_own_cyc) begin
            // Release and hand over in the same edge: no idle gap between owners.
            r_outstanding <= '0;
            r_grant       <= w_pick_onehot;
            if (w_pick_valid) begin
              r_last_idx <= w_pick_idx;
            end else begin
              r_state <= ARB_IDLE;
            end
          end else begin
            r_outstanding <= w_out_next;
          end
        end
        default: begin
          r_state       <= ARB_IDLE;
          r_grant       <= '0;
          r_outstanding <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wishbone_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_wishbone_arbiter                                              |
// | Purpose : Self-checking bench for wishbone_arbiter (3 masters, at most 3   |
// |           outstanding). Directed scenarios plus a randomized run, all      |
// |           checked against a cycle-level reference model of the arbiter.    |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_wishbone_arbiter;

  localparam int N    = 3;
  localparam int MAXO = 3;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SW   = DW / 8;

  logic            CLK;
  logic            RST_N;
  logic [N-1:0]    cyc, stb, we;
  logic [N*AW-1:0] adr;
  logic [N*SW-1:0] sel;
  logic [N*DW-1:0] wdat;
  logic [N-1:0]    m_stall, m_ack, grant;
  logic [DW-1:0]   m_dat;
  logic            s_cyc, s_stb, s_we;
  logic [AW-1:0]   s_adr;
  logic [SW-1:0]   s_sel;
  logic [DW-1:0]   s_wdat;
  logic            s_stall, s_ack;
  logic [DW-1:0]   s_rdat;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: owner (-1 = idle), previous winner, outstanding count.
  int m_owner, m_last, m_out;
  logic [N-1:0] exp_grant, exp_stall, exp_ack;
  logic         exp_scyc, exp_sstb;

  wishbone_arbiter #(
    .N_MASTERS       (N),
    .ADR_W           (AW),
    .DAT_W           (DW),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .M_CYC_I   (cyc),
    .M_STB_I   (stb),
    .M_WE_I    (we),
    .M_ADR_I   (adr),
    .M_SEL_I   (sel),
    .M_DAT_I   (wdat),
    .M_STALL_O (m_stall),
    .M_ACK_O   (m_ack),
    .M_DAT_O   (m_dat),
    .S_CYC_O   (s_cyc),
    .S_STB_O   (s_stb),
    .S_WE_O    (s_we),
    .S_ADR_O   (s_adr),
    .S_SEL_O   (s_sel),
    .S_DAT_O   (s_wdat),
    .S_STALL_I (s_stall),
    .S_ACK_I   (s_ack),
    .S_DAT_I   (s_rdat),
    .GRANT_O   (grant)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish (got timeout, need completion)");
    $fatal(1);
  end

  function automatic int rr_search(input int from);
    for (int k = 1; k <= N; k++) begin
      if (cyc[(from + k) % N]) return (from + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_last  = N - 1;
    m_out   = 0;
  endtask

  task automatic predict();
    exp_grant = '0; exp_stall = '1; exp_ack = '0; exp_scyc = 1'b0; exp_sstb = 1'b0;
    if (m_owner >= 0) begin
      exp_grant[m_owner] = 1'b1;
      exp_scyc           = cyc[m_owner];
      exp_sstb           = stb[m_owner] && (m_out < MAXO);
      exp_stall[m_owner] = s_stall || (m_out == MAXO);
      exp_ack[m_owner]   = s_ack && cyc[m_owner];
    end
  endtask

  // Applies the arbiter rules for one clock edge using the inputs in force.
  task automatic advance();
    int p;
    bit acc;
    if (m_owner < 0) begin
      p = rr_search(m_last);
      if (p >= 0) begin m_owner = p; m_last = p; end
    end else if (!cyc[m_owner]) begin
      m_out   = 0;
      p       = rr_search(m_owner);
      m_owner = p;
      if (p >= 0) m_last = p;
    end else begin
      acc = stb[m_owner] && (m_out < MAXO) && !s_stall;
      if (acc && !s_ack) m_out++;
      else if (!acc && s_ack && m_out > 0) m_out--;
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    advance();
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    cyc = '0; stb = '0; we = '0; adr = '0; sel = '0; wdat = '0;
    s_stall = 1'b0; s_ack = 1'b0; s_rdat = '0;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    cyc = '1; stb = '1; we = '0; adr = '0; sel = '0; wdat = '0;
    s_stall = 1'b0; s_ack = 1'b1; s_rdat = '0;
    repeat (2) @(negedge CLK);
    #2;
    n_checks++; if (s_cyc !== 1'b0) begin n_errors++; $display("FAIL reset_s_cyc: got %b need 0", s_cyc); end
    n_checks++; if (s_stb !== 1'b0) begin n_errors++; $display("FAIL reset_s_stb: got %b need 0", s_stb); end
    n_checks++; if (m_ack !== 3'b000) begin n_errors++; $display("FAIL reset_m_ack: got %b need 000", m_ack); end
    n_checks++; if (m_stall !== 3'b111) begin n_errors++; $display("FAIL reset_m_stall: got %b need 111", m_stall); end
    n_checks++; if (grant !== 3'b000) begin n_errors++; $display("FAIL reset_grant: got %b need 000", grant); end
  endtask

  task automatic test_single_master();
    bit prev_acc;
    int accepted, acks;
    do_reset();
    prev_acc = 0; accepted = 0; acks = 0;
    for (int i = 0; i < 8; i++) begin
      if (i == 0) begin cyc[0] = 1'b1; stb[0] = 1'b1; adr[AW-1:0] = 32'h100; end
      if (accepted == 3) stb[0] = 1'b0;
      if (i == 6) begin cyc[0] = 1'b0; stb[0] = 1'b0; end
      s_ack = prev_acc;
      #2; predict();
      n_checks++; if (grant !== exp_grant || (i >= 1 && i <= 6 && grant !== 3'b001))
        begin n_errors++; $display("FAIL single_grant c%0d: got %b need %b", i, grant, exp_grant); end
      n_checks++; if (m_ack !== exp_ack || m_ack[2:1] !== 2'b00)
        begin n_errors++; $display("FAIL single_ack c%0d: got %b need %b", i, m_ack, exp_ack); end
      acks += int'(m_ack[0]);
      prev_acc = exp_sstb && !s_stall;
      if (prev_acc) begin accepted++; adr[AW-1:0] = adr[AW-1:0] + 32'd4; end
      tick();
    end
    n_checks++; if (acks != 3) begin n_errors++; $display("FAIL single_ack_count: got %0d need 3", acks); end
  endtask

  task automatic test_contention();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      if (i == 0) cyc[1:0] = 2'b11;
      if (i == 5) cyc[0] = 1'b0;
      if (i == 9) cyc[1] = 1'b0;
      #2; predict();
      n_checks++;
      if (grant !== exp_grant || (i >= 1 && i <= 5 && grant !== 3'b001) || (i >= 6 && grant !== 3'b010))
        begin n_errors++; $display("FAIL contention_grant c%0d: got %b need %b", i, grant, exp_grant); end
      n_checks++; if (m_stall !== exp_stall)
        begin n_errors++; $display("FAIL contention_stall c%0d: got %b need %b", i, m_stall, exp_stall); end
      tick();
    end
    #2;
    n_checks++; if (grant !== 3'b000) begin n_errors++; $display("FAIL contention_idle: got %b need 000", grant); end
    cyc[1:0] = 2'b11;
    tick(); #2;
    n_checks++; if (grant !== 3'b001) begin n_errors++; $display("FAIL contention_rotation: got %b need 001", grant); end
    cyc = '0;
    tick();
  endtask

  task automatic test_throttle();
    bit e_stb[9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      if (i == 0) begin cyc[0] = 1'b1; stb[0] = 1'b1; end
      s_ack = (i == 5);
      #2; predict();
      n_checks++; if (s_stb !== e_stb[i] || s_stb !== exp_sstb)
        begin n_errors++; $display("FAIL throttle_stb c%0d: got %b need %b", i, s_stb, e_stb[i]); end
      n_checks++; if (m_stall !== exp_stall || (i >= 1 && m_stall[0] !== !e_stb[i]))
        begin n_errors++; $display("FAIL throttle_stall c%0d: got %b need %b", i, m_stall, exp_stall); end
      tick();
    end
    cyc = '0; stb = '0;
    tick();
  endtask

  task automatic test_slave_stall();
    bit e_stb[9]   = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    bit e_stall[9] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      if (i == 0) begin cyc[0] = 1'b1; stb[0] = 1'b1; adr[AW-1:0] = 32'hA0; end
      s_stall = (i >= 3 && i <= 6);
      #2; predict();
      n_checks++; if (s_stb !== e_stb[i] || s_stb !== exp_sstb)
        begin n_errors++; $display("FAIL sstall_stb c%0d: got %b need %b", i, s_stb, e_stb[i]); end
      n_checks++; if (m_stall[0] !== e_stall[i] || m_stall !== exp_stall)
        begin n_errors++; $display("FAIL sstall_m_stall c%0d: got %b need %b", i, m_stall, exp_stall); end
      if (i >= 1) begin
        n_checks++; if (s_adr !== 32'hA0) begin n_errors++; $display("FAIL sstall_adr c%0d: got %h need a0", i, s_adr); end
      end
      tick();
    end
    cyc = '0; stb = '0;
    tick();
  endtask

  task automatic test_abort();
    bit         e_stb[10]   = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [2:0] e_grant[10] = '{3'd0, 3'd2, 3'd2, 3'd2, 3'd0, 3'd0, 3'd2, 3'd2, 3'd2, 3'd2};
    do_reset();
    for (int i = 0; i < 10; i++) begin
      if (i == 0) begin cyc[1] = 1'b1; stb[1] = 1'b1; end
      if (i == 3) begin cyc[1] = 1'b0; stb[1] = 1'b0; end
      if (i == 5) begin cyc[1] = 1'b1; stb[1] = 1'b1; end
      s_ack = (i == 3 || i == 4);
      #2; predict();
      n_checks++; if (s_stb !== e_stb[i] || s_stb !== exp_sstb)
        begin n_errors++; $display("FAIL abort_stb c%0d: got %b need %b", i, s_stb, e_stb[i]); end
      n_checks++; if (grant !== e_grant[i] || grant !== exp_grant)
        begin n_errors++; $display("FAIL abort_grant c%0d: got %b need %b", i, grant, e_grant[i]); end
      n_checks++; if (m_ack !== 3'b000)
        begin n_errors++; $display("FAIL abort_ack c%0d: got %b need 000", i, m_ack); end
      if (i == 3) begin
        n_checks++; if (s_cyc !== 1'b0) begin n_errors++; $display("FAIL abort_s_cyc: got %b need 0", s_cyc); end
      end
      tick();
    end
    cyc = '0; stb = '0;
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    cyc[0] = 1'b1; stb[0] = 1'b1;
    repeat (4) tick();
    #2;
    s_ack = 1'b1;
    RST_N = 1'b0;
    #1;
    n_checks++; if (s_cyc !== 1'b0) begin n_errors++; $display("FAIL rstmid_s_cyc: got %b need 0", s_cyc); end
    n_checks++; if (grant !== 3'b000) begin n_errors++; $display("FAIL rstmid_grant: got %b need 000", grant); end
    n_checks++; if (m_stall !== 3'b111) begin n_errors++; $display("FAIL rstmid_stall: got %b need 111", m_stall); end
    n_checks++; if (m_ack !== 3'b000) begin n_errors++; $display("FAIL rstmid_ack: got %b need 000", m_ack); end
    @(negedge CLK);
    RST_N = 1'b1; model_reset();
    cyc = '1; stb = '0; s_ack = 1'b0;
    tick(); #2; predict();
    n_checks++; if (grant !== 3'b001 || grant !== exp_grant)
      begin n_errors++; $display("FAIL rstmid_first_win: got %b need 001", grant); end
    cyc = '0;
    tick();
  endtask

  task automatic test_random();
    int todo[N];
    int s_pend, prev_owner;
    bit acc, released, taken;
    do_reset();
    for (int m = 0; m < N; m++) todo[m] = 0;
    s_pend = 0;
    for (int c = 0; c < 2000; c++) begin
      #2; predict();
      n_checks++; if (grant !== exp_grant) begin n_errors++; $display("FAIL rnd_grant c%0d: got %b need %b", c, grant, exp_grant); end
      n_checks++; if (s_cyc !== exp_scyc || s_stb !== exp_sstb)
        begin n_errors++; $display("FAIL rnd_slave_req c%0d: got cyc=%b stb=%b need cyc=%b stb=%b", c, s_cyc, s_stb, exp_scyc, exp_sstb); end
      n_checks++; if (m_stall !== exp_stall) begin n_errors++; $display("FAIL rnd_stall c%0d: got %b need %b", c, m_stall, exp_stall); end
      n_checks++; if (m_ack !== exp_ack) begin n_errors++; $display("FAIL rnd_ack c%0d: got %b need %b", c, m_ack, exp_ack); end
      n_checks++; if (m_dat !== s_rdat) begin n_errors++; $display("FAIL rnd_m_dat c%0d: got %h need %h", c, m_dat, s_rdat); end
      if (m_owner >= 0) begin
        n_checks++;
        if (s_we !== we[m_owner] || s_adr !== adr[m_owner*AW +: AW] ||
            s_sel !== sel[m_owner*SW +: SW] || s_wdat !== wdat[m_owner*DW +: DW])
          begin n_errors++; $display("FAIL rnd_fields c%0d: got adr=%h dat=%h need adr=%h dat=%h", c, s_adr, s_wdat,
                                     adr[m_owner*AW +: AW], wdat[m_owner*DW +: DW]); end
      end
      acc        = exp_sstb && !s_stall;
      prev_owner = m_owner;
      released   = (m_owner >= 0) && !cyc[m_owner];
      tick();
      // Slave side: forgets pending work when the bus cycle ends.
      if (released || prev_owner < 0) s_pend = 0;
      else begin
        if (acc) s_pend++;
        if (s_ack && s_pend > 0) s_pend--;
      end
      s_ack   = (s_pend > 0 && $urandom_range(0, 9) < 6) || ($urandom_range(0, 29) == 0);
      s_stall = ($urandom_range(0, 3) == 0);
      s_rdat  = $urandom();
      // Masters: hold a stalled request stable, otherwise issue or wind down.
      for (int m = 0; m < N; m++) begin
        taken = acc && (prev_owner == m);
        if (taken) todo[m]--;
        if (!cyc[m]) begin
          stb[m] = 1'b0;
          if ($urandom_range(0, 3) == 0) begin cyc[m] = 1'b1; todo[m] = $urandom_range(1, 5); end
        end else if ($urandom_range(0, 59) == 0) begin
          cyc[m] = 1'b0; stb[m] = 1'b0;
        end else if (stb[m] && !taken) begin
          stb[m] = 1'b1;
        end else if (todo[m] > 0 && $urandom_range(0, 9) < 7) begin
          stb[m]               = 1'b1;
          we[m]                = 1'($urandom_range(0, 1));
          adr[m*AW +: AW]      = $urandom();
          sel[m*SW +: SW]      = SW'($urandom());
          wdat[m*DW +: DW]     = $urandom();
        end else begin
          stb[m] = 1'b0;
          if (todo[m] <= 0 && (m_owner != m || m_out == 0)) cyc[m] = 1'b0;
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_master();
    test_contention();
    test_throttle();
    test_slave_stall();
    test_abort();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
